// File: rtl/program_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : program_mem_arbiter
// Brief   : Round-robin arbiter of fetch read channels onto one program memory
// Revision: 1.0
// ============================================================================
module program_mem_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,
  output logic                                 mem_read_valid,
  output logic [ADDR_BITS-1:0]                 mem_read_address,
  input  logic                                 mem_read_ready,
  input  logic [DATA_BITS-1:0]                 mem_read_data
);

  localparam int PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam logic [PTR_W-1:0] c_last = PTR_W'(NUM_CONSUMERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_RELEASE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [PTR_W-1:0] r_grant;
  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] w_pick;
  logic             w_found;

  // Circular search starting at r_rr_ptr; wrap is explicit so any consumer
  // count works, not just powers of two.
  always_comb begin
    int               v_idx;
    logic [PTR_W-1:0] v_sel;
    w_found = 1'b0;
    w_pick  = '0;
    v_idx   = 0;
    v_sel   = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      v_idx = int'(r_rr_ptr) + i;
      if (v_idx >= NUM_CONSUMERS) begin
        v_idx = v_idx - NUM_CONSUMERS;
      end
      v_sel = PTR_W'(v_idx);
      if (!w_found && consumer_read_valid[v_sel]) begin
        w_found = 1'b1;
        w_pick  = v_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state             <= ST_IDLE;
      r_grant             <= '0;
      r_rr_ptr            <= '0;
      consumer_read_ready <= '0;
      consumer_read_data  <= '0;
      mem_read_valid      <= 1'b0;
      mem_read_address    <= '0;
    end else begin
      consumer_read_ready <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant          <= w_pick;
            mem_read_valid   <= 1'b1;
            mem_read_address <= consumer_read_address[w_pick*ADDR_BITS +: ADDR_BITS];
            r_state          <= ST_MEM_WAIT;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_read_ready) begin
            consumer_read_data[r_grant*DATA_BITS +: DATA_BITS] <= mem_read_data;
            consumer_read_ready[r_grant] <= 1'b1;
            mem_read_valid               <= 1'b0;
            r_state                      <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          // Hold off until the served unit drops valid so it is not served twice.
          if (!consumer_read_valid[r_grant]) begin
            r_rr_ptr <= (r_grant == c_last) ? '0 : r_grant + 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/program_mem_arbiter.md
Name: program_mem_arbiter

Overview:
- Sits upstream of the per-thread instruction fetch units.
- Multiplexes NUM_CONSUMERS fetch read channels (valid/ready/address/data) onto a single program-memory read channel using round-robin arbitration.
- Exactly one memory transaction is outstanding at a time; the returned instruction is routed back to the granted consumer with a one-cycle ready pulse.

Parameters:
- ADDR_BITS, 8, program memory address width
- DATA_BITS, 16, instruction word width
- NUM_CONSUMERS, 4, number of fetch units served (>=1)

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- consumer_read_valid  input  NUM_CONSUMERS  per-consumer read request, held until served
- consumer_read_address  input  NUM_CONSUMERS x ADDR_BITS  per-consumer address, stable while valid
- consumer_read_ready  output  NUM_CONSUMERS  per-consumer one-cycle completion pulse
- consumer_read_data  output  NUM_CONSUMERS x DATA_BITS  per-consumer returned instruction, held
- mem_read_valid  output  1  request to program memory
- mem_read_address  output  ADDR_BITS  program memory address
- mem_read_ready  input  1  memory response strobe, data valid this cycle
- mem_read_data  input  DATA_BITS  memory read data

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- All outputs are registered.
- Reset values: consumer_read_ready=0, consumer_read_data=0 (all lanes), mem_read_valid=0, mem_read_address=0, grant index=0, rr_ptr=0, state=IDLE.
- Reset mid-transaction abandons the transaction. A mem_read_ready arriving after reset is ignored.
- IDLE:
  - If any consumer_read_valid is set, grant the first set bit searching circularly from rr_ptr (rr_ptr, rr_ptr+1, ..., wrapping at NUM_CONSUMERS-1 -> 0).
  - Latch the grant index; set mem_read_valid<=1 and mem_read_address<=consumer_read_address[grant]; go to MEM_WAIT.
  - If no request is set, stay in IDLE.
- MEM_WAIT:
  - Hold mem_read_valid=1 and the address until mem_read_ready=1.
  - On mem_read_ready: consumer_read_data[grant]<=mem_read_data, consumer_read_ready[grant]<=1, mem_read_valid<=0; go to RELEASE.
  - mem_read_ready is ignored in every state except MEM_WAIT.
  - If the consumer drops valid during MEM_WAIT, the transaction still completes and the ready pulse is still issued.
- RELEASE:
  - consumer_read_ready<=0, so the pulse is exactly 1 cycle.
  - Wait until consumer_read_valid[grant]==0, so a fetch unit that holds valid for a cycle after ready is not served twice.
  - Then rr_ptr<=(grant+1) mod NUM_CONSUMERS; go to IDLE.
- Latency: with memory asserting ready in the first MEM_WAIT cycle, consumer_read_ready rises 2 cycles after consumer_read_valid is sampled in IDLE. Each extra memory stall cycle adds 1 cycle.
- consumer_read_data lanes change only on a response to that lane; all other lanes hold their value.
- At most one bit of consumer_read_ready is high in any cycle.
- Throughput: minimum 4 cycles per transaction (IDLE, MEM_WAIT, RELEASE, and the RELEASE cycle in which valid drops).
- NUM_CONSUMERS=1: rr_ptr is constant 0; behaviour is otherwise identical.
- rr_ptr width is max(1, $clog2(NUM_CONSUMERS)); wrap is explicit and does not rely on power-of-two overflow.

Test Plan:
- Single request: consumer 2 requests addr 0x3C, memory returns 0xA5F0 with ready in the first MEM_WAIT cycle -> mem_read_address=0x3C; consumer_read_ready[2] is a one-cycle pulse 2 cycles after the request is sampled; consumer_read_data[2]=0xA5F0; other lanes remain 0.
- Simultaneous requests: consumers 0 and 3 request together from reset (rr_ptr=0) -> 0 served first, then 3; a further request from 0 issued while 3 is in flight is served after 3.
- Fairness: all 4 consumers hold valid continuously, re-requesting 1 cycle after each ready -> grant order 0,1,2,3,0,1,... with no lane served twice in a row.
- Memory stall: mem_read_ready held low for 5 cycles -> mem_read_valid and mem_read_address are stable for all 5 cycles; the ready pulse occurs 1 cycle after mem_read_ready.
- Sticky valid: consumer 1 holds valid 3 cycles past its ready pulse -> no second mem_read_valid for consumer 1 until valid drops; the next transaction starts from IDLE afterwards.
- Reset mid-operation: assert reset in MEM_WAIT, then memory asserts ready -> all outputs are 0, no ready pulse, rr_ptr=0, and the next request is serviced normally.
